mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the core's request unit: serves instruction-fetch and data load/store requests, returns i_ack/d_ack, the fetched instruction and load data.
- Arbitrates both request channels onto one Wishbone-classic master port (single outstanding transfer).
- Sits between the datapath/request unit and the SoC bus.
- A bounded wait timer terminates hung transfers.

Parameters:
- TIMEOUT, 255: max wait cycles for wb_ack_i before forced termination; range 1..65535.
- RESET_PC, 32'h0000_0000: instruction register value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_address  in  32  fetch address
- d_ren  in  1  data load request; held until d_ack
- d_wen  in  1  data store request; held until d_ack
- d_address  in  32  load/store address
- mem_store  in  32  store data
- instruction  out  32  fetched word, registered
- memload  out  32  load data, registered
- i_ack  out  1  one-cycle fetch completion pulse
- d_ack  out  1  one-cycle data completion pulse
- bus_err  out  1  one-cycle pulse on timeout termination
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  word-aligned address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects, always 4'hF
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset values: all outputs 0 except instruction = RESET_PC and wb_sel_o = 4'hF. FSM = IDLE. Timer = 0.
- Reset mid-transfer: cyc/stb drop on the next edge; no ack or err is issued for the aborted request.
- FSM states: IDLE, DBUS, IBUS, DONE.
- IDLE:
  - d_ren|d_wen -> DBUS (data has priority, because the core is frozen on data).
  - else i_req -> IBUS.
  - On entry to DBUS/IBUS, latch the address, write data, we and channel; assert cyc/stb/we from the next cycle.
- d_ren and d_wen both high: treated as a store; exactly one d_ack.
- wb_adr_o = {addr[31:2], 2'b00}. Low address bits are ignored; misalignment is not an error.
- DBUS/IBUS: hold all bus outputs stable until wb_ack_i is sampled high.
  - On that edge: deassert cyc/stb/we.
  - Register wb_dat_i into memload (data read) or instruction (fetch). Stores leave memload unchanged.
  - Pulse d_ack or i_ack for exactly one cycle.
  - Go to DONE.
- Latency: request seen at edge 0, stb high in cycle 1. A zero-wait slave acks in cycle 1, so the ack pulse and valid data appear in cycle 2. Each slave wait state adds 1 cycle.
- Timer: counts cycles in DBUS/IBUS and clears on state entry.
  - If it reaches TIMEOUT without wb_ack_i, terminate as above with read data forced to 0, pulse bus_err together with the ack, go to DONE.
  - wb_ack_i in the same cycle as expiry counts as a normal completion (no err).
- DONE: lasts one cycle, requests ignored (the requester drops its request after the ack), then -> IDLE.
  - Back-to-back issue rate: one transfer per 3 cycles minimum with a zero-wait slave.
- Request lines are sampled only in IDLE; changes during a transfer have no effect on it.
- i_ack and d_ack are never high together. instruction/memload hold their value between transfers.

Decomposition:
- Package mem_responder_pkg:
  - state enum (IDLE, DBUS, IBUS, DONE)
  - WB_SEL_ALL = 4'hF
  - channel enum (CH_INSTR, CH_DATA)
- Sub-module wait_timer: clear, enable, expired output, width $clog2(TIMEOUT+1).

Test Plan:
- Fetch, zero-wait slave: i_req=1, i_address=32'h0000_0104, slave returns 32'h0010_0093 in stb cycle -> wb_adr_o=32'h104, we=0, i_ack in cycle 2, instruction=32'h0010_0093.
- Store with 3 wait states: d_wen=1, d_address=32'h2003, mem_store=32'hDEAD_BEEF -> wb_adr_o=32'h2000, wb_we_o=1, wb_dat_o=DEADBEEF, d_ack at cycle 5, memload unchanged.
- Simultaneous i_req and d_ren at reset release -> data transfer first with d_ack, DONE, then fetch with i_ack. Acks never overlap.
- Timeout: TIMEOUT=4, slave never acks on a load -> stb high 4 cycles, then d_ack and bus_err pulse together, memload=0.
- Reset mid-transfer: rst asserted during an IBUS wait -> next cycle cyc=stb=0, no i_ack, instruction=RESET_PC. A subsequent fetch completes normally.
- d_ren and d_wen both high -> single write cycle (we=1), one d_ack.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its wait timer.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBUS = 2'd1,
        IBUS = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        CH_INSTR = 1'b0,
        CH_DATA  = 1'b1
    } chan_e;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts bus wait cycles; expired_o is high in the TIMEOUT-th enabled cycle
// since the last clear, so a transfer is cut after exactly TIMEOUT strobe cycles.
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Saturates at LAST; the FSM leaves the bus state on expiry anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_responder.sv
// Serves instruction fetches and data loads/stores over one Wishbone-classic
// master port, one transfer at a time, with a bounded wait for the slave.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_address,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_address,
    input  logic [31:0] mem_store,
    output logic [31:0] instruction,
    output logic [31:0] memload,
    output logic        i_ack,
    output logic        d_ack,
    output logic        bus_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    state_e      state_q, state_d;
    chan_e       ch_q, ch_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] memload_q, memload_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;

    logic        in_bus;
    logic        expired;
    logic [31:0] rdata;

    assign in_bus = (state_q == DBUS) || (state_q == IBUS);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (!in_bus),
        .en_i      (in_bus),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        instr_d   = instr_q;
        memload_d = memload_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        // A slave ack on the expiry cycle wins over the timeout.
        rdata     = wb_ack_i ? wb_dat_i : 32'h0;

        unique case (state_q)
            IDLE: begin
                // Data first: the core is stalled while a load/store waits.
                if (d_ren || d_wen) begin
                    state_d = DBUS;
                    ch_d    = CH_DATA;
                    cyc_d   = 1'b1;
                    we_d    = d_wen;
                    adr_d   = word_align(d_address);
                    dat_d   = mem_store;
                end else if (i_req) begin
                    state_d = IBUS;
                    ch_d    = CH_INSTR;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = word_align(i_address);
                    dat_d   = 32'h0;
                end
            end
            DBUS, IBUS: begin
                if (wb_ack_i || expired) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = !wb_ack_i;
                    if (ch_q == CH_DATA) begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            memload_d = rdata;
                        end
                    end else begin
                        i_ack_d = 1'b1;
                        instr_d = rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= CH_INSTR;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            instr_q   <= RESET_PC;
            memload_q <= 32'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            instr_q   <= instr_d;
            memload_q <= memload_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
        end
    end

    assign instruction = instr_q;
    assign memload     = memload_q;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign bus_err     = err_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = WB_SEL_ALL;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a transaction-level requester/slave
// model predicts bus fields, ack latency, timeout errors and returned data.
module tb_mem_responder;

    localparam int unsigned TIMEOUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam int K_FETCH = 0, K_LOAD = 1, K_STORE = 2, K_BOTH = 3;
    localparam int NEVER = -1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_ren, d_wen;
    logic [31:0] i_address, d_address, mem_store;
    logic [31:0] instruction, memload;
    logic        i_ack, d_ack, bus_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instr, exp_memload;

    always #5 clk = ~clk;

    mem_responder #(
        .TIMEOUT  (TIMEOUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_address   (i_address),
        .d_ren       (d_ren),
        .d_wen       (d_wen),
        .d_address   (d_address),
        .mem_store   (mem_store),
        .instruction (instruction),
        .memload     (memload),
        .i_ack       (i_ack),
        .d_ack       (d_ack),
        .bus_err     (bus_err),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Called at a negedge where the DUT is idle; the next posedge is edge 0.
    // The slave acks after `wt` wait states (NEVER = no ack at all).
    task automatic xfer(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wt, input logic [31:0] rdata);
        int  n = 0;
        int  nstb = 0;
        int  exp_stb;
        bit  err, is_data, is_wr, got;
        is_data = (kind != K_FETCH);
        is_wr   = (kind == K_STORE) || (kind == K_BOTH);
        err     = (wt < 0) || (wt >= int'(TIMEOUT));
        exp_stb = err ? int'(TIMEOUT) : wt + 1;
        got     = 1'b0;
        if (is_data) begin
            d_ren     = (kind == K_LOAD) || (kind == K_BOTH);
            d_wen     = is_wr;
            d_address = addr;
            mem_store = wdata;
        end else begin
            i_req     = 1'b1;
            i_address = addr;
        end
        wb_ack_i = 1'b0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (i_ack || d_ack) begin
                got = 1'b1;
                wb_ack_i = 1'b0;
                break;
            end
            if (wb_stb_o) begin
                chk("cyc", 32'(wb_cyc_o), 32'd1);
                chk("adr", wb_adr_o, {addr[31:2], 2'b00});
                chk("we", 32'(wb_we_o), 32'(is_wr));
                chk("sel", 32'(wb_sel_o), 32'hF);
                if (is_wr) chk("wdat", wb_dat_o, wdata);
                nstb++;
                wb_ack_i = (wt >= 0) && (nstb - 1 == wt);
                wb_dat_i = wb_ack_i ? rdata : $urandom;
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = $urandom;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (!is_data) exp_instr = err ? 32'h0 : rdata;
        else if (!is_wr) exp_memload = err ? 32'h0 : rdata;
        chk("latency", 32'(n), 32'(exp_stb + 1));
        chk("stb_cycles", 32'(nstb), 32'(exp_stb));
        chk("ack_kind", 32'({i_ack, d_ack}), is_data ? 32'd1 : 32'd2);
        chk("bus_err", 32'(bus_err), 32'(err));
        chk("instruction", instruction, exp_instr);
        chk("memload", memload, exp_memload);
        if (is_data) begin
            d_ren = 1'b0;
            d_wen = 1'b0;
        end else begin
            i_req = 1'b0;
        end
        @(negedge clk);
        chk("ack_pulse", 32'({i_ack, d_ack, bus_err, wb_cyc_o}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        i_address = 32'h0; d_address = 32'h0; mem_store = 32'h0;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        exp_instr = RESET_PC;
        exp_memload = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_instr", instruction, RESET_PC);
        chk("rst_memload", memload, 32'h0);
        chk("rst_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
        chk("rst_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", 32'(wb_sel_o), 32'hF);

        // Fetch and load pending at reset release: load must go first.
        rst = 1'b0;
        i_req = 1'b1;
        i_address = 32'h0000_0200;
        xfer(K_LOAD, 32'h0000_3008, 32'h0, 0, 32'h1234_5678);
        xfer(K_FETCH, 32'h0000_0200, 32'h0, 0, 32'h0000_0013);

        xfer(K_FETCH, 32'h0000_0104, 32'h0, 0, 32'h0010_0093);
        xfer(K_STORE, 32'h0000_2003, 32'hDEAD_BEEF, 3, 32'h5555_5555);
        xfer(K_LOAD, 32'h0000_4000, 32'h0, NEVER, 32'hFFFF_FFFF);
        xfer(K_BOTH, 32'h0000_5001, 32'hCAFE_F00D, 1, 32'h7777_7777);
        xfer(K_FETCH, 32'h0000_0108, 32'h0, int'(TIMEOUT) - 1, 32'hA5A5_A5A5);

        // Reset while a fetch is waiting on the slave.
        i_req = 1'b1;
        i_address = 32'h0000_0300;
        wb_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bus", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
        chk("mid_rst_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
        chk("mid_rst_instr", instruction, RESET_PC);
        rst = 1'b0;
        i_req = 1'b0;
        exp_instr = RESET_PC;
        exp_memload = 32'h0;
        @(negedge clk);
        xfer(K_FETCH, 32'h0000_0304, 32'h0, 1, 32'h0020_0113);

        for (int t = 0; t < 60; t++) begin
            int k;
            int w;
            k = int'($urandom_range(0, 3));
            w = int'($urandom_range(0, 6));
            if (w == 6) w = NEVER;
            xfer(k, $urandom, $urandom, w, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
